// File: rtl/subtrator_serial_ctrl_if.sv
// Handshake and operand bundle for the bit-serial subtractor.
// Optional flag outputs exist only when SUBTRATOR_SERIAL_FLAGS_EN is defined.
interface subtrator_serial_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUBTRATOR_SERIAL_FLAGS_EN
    logic             zero;
    logic             lt;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, zero, lt
    );
    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, zero, lt
    );
`else
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );
    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
`endif
endinterface

// File: rtl/subtrator_serial_ctrl.sv
// Bit-serial subtractor: one full-subtractor bit per SHIFT cycle, LSB first.
// Define SUBTRATOR_SERIAL_FLAGS_EN to add registered zero/lt result flags.
module subtrator_serial_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    subtrator_serial_ctrl_if.slave bus
);
    localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
`ifdef SUBTRATOR_SERIAL_FLAGS_EN
    logic             zero_q, zero_d;
    logic             lt_q, lt_d;
`endif

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] sr_shifted;

    // Full-subtractor cell on the current LSBs of the operand shifters
    always_comb begin
        d_bit      = a_q[0] ^ b_q[0] ^ br_q;
        br_next    = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
        sr_shifted = {d_bit, sr_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sr_d    = sr_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SUBTRATOR_SERIAL_FLAGS_EN
        zero_d  = zero_q;
        lt_d    = lt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.bin;
                    sr_d    = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d  = a_q >> 1;
                b_d  = b_q >> 1;
                sr_d = sr_shifted;
                br_d = br_next;
                // Visible outputs change only on the edge that enters DONE
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    diff_d  = sr_shifted;
                    bout_d  = br_next;
`ifdef SUBTRATOR_SERIAL_FLAGS_EN
                    zero_d  = (sr_shifted == '0);
                    lt_d    = br_next;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sr_q    <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SUBTRATOR_SERIAL_FLAGS_EN
            zero_q  <= 1'b0;
            lt_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sr_q    <= sr_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SUBTRATOR_SERIAL_FLAGS_EN
            zero_q  <= zero_d;
            lt_q    <= lt_d;
`endif
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SUBTRATOR_SERIAL_FLAGS_EN
    assign bus.zero = zero_q;
    assign bus.lt   = lt_q;
`endif
endmodule

// File: tb/tb_subtrator_serial_ctrl.sv
// Directed self-checking bench for subtrator_serial_ctrl at WIDTH=8.
// Flag outputs are checked when SUBTRATOR_SERIAL_FLAGS_EN is defined.
module tb_subtrator_serial_ctrl;
    logic clk;
    logic rst_n;
    int   nvec;
    int   nerr;
    logic [7:0] prev_diff;
    logic       prev_bout;

    subtrator_serial_ctrl_if #(.WIDTH(8)) bus ();

    subtrator_serial_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one operation, scramble inputs afterwards, check timing and result.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                          input logic tbin, input logic [7:0] ed, input logic eb,
                          input logic ez);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_;
        bus.bin   = tbin;
        tick;
        bus.start = 1'b0;
        bus.a     = ~ta;
        bus.b     = ~tb_;
        bus.bin   = ~tbin;
        for (int i = 1; i <= 8; i++) begin
            chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
            chk({tag, "_nodone"}, {31'd0, bus.done}, 32'd0);
            chk({tag, "_diffhold"}, {24'd0, bus.diff}, {24'd0, prev_diff});
            chk({tag, "_bouthold"}, {31'd0, bus.bout}, {31'd0, prev_bout});
            tick;
        end
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        chk({tag, "_idlebusy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_diff"}, {24'd0, bus.diff}, {24'd0, ed});
        chk({tag, "_bout"}, {31'd0, bus.bout}, {31'd0, eb});
`ifdef SUBTRATOR_SERIAL_FLAGS_EN
        chk({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, ez});
        chk({tag, "_lt"}, {31'd0, bus.lt}, {31'd0, eb});
`else
        if (ez === 1'bx) $display("unexpected zero flag");
`endif
        prev_diff = ed;
        prev_bout = eb;
        tick;
        chk({tag, "_pulse1"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_held"}, {24'd0, bus.diff}, {24'd0, ed});
    endtask

    initial begin
        int dcnt;
        int dcyc;
        logic [7:0] dval;
        nvec      = 0;
        nerr      = 0;
        prev_diff = 8'h00;
        prev_bout = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.a     = 8'h11;
        bus.b     = 8'h22;
        bus.bin   = 1'b0;

        // Reset with start high: must stay idle and cleared
        tick;
        tick;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_diff", {24'd0, bus.diff}, 32'd0);
        chk("rst_bout", {31'd0, bus.bout}, 32'd0);
`ifdef SUBTRATOR_SERIAL_FLAGS_EN
        chk("rst_zero", {31'd0, bus.zero}, 32'd0);
        chk("rst_lt", {31'd0, bus.lt}, 32'd0);
`endif
        bus.start = 1'b0;
        rst_n     = 1'b1;
        tick;
        chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);

        run_op("sub5_3", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        run_op("sub3_5", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        run_op("sub0_0b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op("sub7a", 8'h7A, 8'h7A, 1'b0, 8'h00, 1'b0, 1'b1);
        run_op("sub0_ffb", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1);
        run_op("sub80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0);

        // Second start mid-operation must be ignored
        bus.start = 1'b1;
        bus.a     = 8'h05;
        bus.b     = 8'h03;
        bus.bin   = 1'b0;
        tick;
        bus.start = 1'b0;
        dcnt = 0;
        dcyc = 0;
        dval = 8'h00;
        for (int n = 1; n <= 16; n++) begin
            if (bus.done) begin
                dcnt++;
                dcyc = n;
                dval = bus.diff;
            end
            if (n == 2) begin
                bus.start = 1'b1;
                bus.a     = 8'h50;
                bus.b     = 8'h01;
                bus.bin   = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            tick;
        end
        chk("ign_donecnt", dcnt, 32'd1);
        chk("ign_donecyc", dcyc, 32'd9);
        chk("ign_diff", {24'd0, dval}, 32'h02);

        // Reset in the middle of SHIFT aborts without a done pulse
        bus.start = 1'b1;
        bus.a     = 8'h03;
        bus.b     = 8'h05;
        bus.bin   = 1'b0;
        tick;
        bus.start = 1'b0;
        tick;
        tick;
        tick;
        chk("mid_busy", {31'd0, bus.busy}, 32'd1);
        rst_n     = 1'b0;
        bus.start = 1'b1;
        tick;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_diff", {24'd0, bus.diff}, 32'd0);
        chk("abort_bout", {31'd0, bus.bout}, 32'd0);
        tick;
        chk("abort_nostart", {31'd0, bus.busy}, 32'd0);
        rst_n     = 1'b1;
        bus.start = 1'b0;
        dcnt = 0;
        for (int n = 0; n < 10; n++) begin
            if (bus.done) dcnt++;
            tick;
        end
        chk("abort_nodone", dcnt, 32'd0);
        prev_diff = 8'h00;
        prev_bout = 1'b0;
        run_op("after_rst", 8'hC8, 8'h37, 1'b1, 8'h90, 1'b0, 1'b0);

        // start held high: back-to-back every WIDTH+2 cycles
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'h01;
        bus.bin   = 1'b0;
        tick;
        for (int n = 1; n <= 30; n++) begin
            chk("b2b_done", {31'd0, bus.done}, ((n % 10) == 9) ? 32'd1 : 32'd0);
            if ((n % 10) == 9) begin
                chk("b2b_diff", {24'd0, bus.diff}, 32'hFE);
                chk("b2b_bout", {31'd0, bus.bout}, 32'd0);
            end
            tick;
        end
        bus.start = 1'b0;
        for (int n = 0; n < 12; n++) tick;
        chk("final_idle", {31'd0, bus.busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
